// File: rtl/seg_display_scanner.sv
// seg_display_scanner
// Time-multiplexes NUM_DIGITS packed hex digits onto a common-anode 7-segment
// display. All digits and decimal points are snapshotted once per frame, so a
// frame never shows digits taken from two different counts. Each digit slot
// begins with BLANK_CYCLES of all-anodes-off to suppress ghosting.
// Optional macro SEG_LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0
// is never blanked); a blanked slot still pulses its anode so brightness stays
// uniform, and its decimal point is still driven from the dp snapshot.
module seg_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0]         CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [6:0]            SEG_OFF   = 7'h7F;

    // Active-low segment pattern (gfedcba) for one hex value.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Scan position and frame snapshot.
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;

    // Registered outputs.
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end_s;
    logic                    frame_end_s;
    logic [3:0]              cur_dig_s;
    logic                    cur_dp_s;
    logic                    cur_blank_s;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Bit i set when digit i and every digit above it are zero (never digit 0).
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end else begin
                all_zero = all_zero;
            end
            m[i] = all_zero;
        end
        return m;
    endfunction

    logic [NUM_DIGITS-1:0] blank_q;

    // Blank mask follows the snapshot; it only changes when the snapshot loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= lz_mask({(4*NUM_DIGITS){1'b0}});
        end else begin
            blank_q <= lz_mask(snap_dig_d);
        end
    end

    assign cur_blank_s = blank_q[idx_q];
`else
    assign cur_blank_s = 1'b0;
`endif

    assign slot_end_s  = (cnt_q == CNT_LAST);
    assign frame_end_s = slot_end_s && (idx_q == IDX_LAST);
    assign cur_dig_s   = snap_dig_q[{idx_q, 2'b00} +: 4];
    assign cur_dp_s    = snap_dp_q[idx_q];

    // Next scan position and snapshot; disable parks the scan and tracks inputs.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        if (!en) begin
            cnt_d      = '0;
            idx_d      = '0;
            snap_dig_d = digits;
            snap_dp_d  = dp_mask;
        end else begin
            if (slot_end_s) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            if (frame_end_s) begin
                snap_dig_d = digits;
                snap_dp_d  = dp_mask;
            end else begin
                snap_dig_d = snap_dig_q;
                snap_dp_d  = snap_dp_q;
            end
        end
    end

    // Next display drive: dark during disable and the slot's blanking window.
    always_comb begin
        an_d         = AN_OFF;
        seg_d        = SEG_OFF;
        dp_d         = 1'b1;
        frame_done_d = 1'b0;
        if (!en) begin
            frame_done_d = 1'b0;
        end else begin
            frame_done_d = frame_end_s;
            if (cnt_q < CNT_BLANK) begin
                an_d = AN_OFF;
            end else begin
                an_d  = ~(AN_ONE << idx_q);
                seg_d = cur_blank_s ? SEG_OFF : hex_to_seg(cur_dig_s);
                dp_d  = ~cur_dp_s;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_dig_q   <= '0;
            snap_dp_q    <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (4 digits, 8-cycle slots,
// 2 blank cycles). A frame-level reference model predicts every output cycle.
module tb_seg_display_scanner;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic          clk;
    logic          reset;
    logic          en;
    logic [15:0]   digits;
    logic [3:0]    dp_mask;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_done;

    seg_display_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: position in frame, snapshot, and predicted outputs.
    int          m_cnt;
    int          m_idx;
    logic [15:0] m_snap;
    logic [3:0]  m_sdp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    int n_cmp;
    int n_fail;
    int fd_count;

    function automatic bit lead_zero(input logic [15:0] s, input int i);
        bit r;
        r = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (i != 0) r = ((s >> (4 * i)) == 16'h0000);
`endif
        return r;
    endfunction

    // Predict the next outputs from the current model state and inputs, advance
    // the model, clock the DUT and compare.
    task automatic tick();
        logic [3:0] dg;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fd  = 1'b0;
        if (reset) begin
            m_cnt  = 0;
            m_idx  = 0;
            m_snap = 16'h0000;
            m_sdp  = 4'h0;
        end else if (!en) begin
            m_cnt  = 0;
            m_idx  = 0;
            m_snap = digits;
            m_sdp  = dp_mask;
        end else begin
            if (m_cnt >= BC) begin
                dg    = 4'((m_snap >> (4 * m_idx)) & 16'h000F);
                e_an  = ~(4'b0001 << m_idx);
                e_seg = lead_zero(m_snap, m_idx) ? 7'h7F : seg_tbl[dg];
                e_dp  = ~m_sdp[m_idx];
            end
            e_fd = (m_cnt == RD - 1) && (m_idx == ND - 1);
            if (e_fd) begin
                m_snap = digits;
                m_sdp  = dp_mask;
            end
            m_cnt = (m_cnt + 1) % RD;
            if (m_cnt == 0) m_idx = (m_idx + 1) % ND;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        assert (an === e_an) else begin
            n_fail++;
            $error("FAIL an: observed %h expected %h at %0t", an, e_an, $time);
        end
        n_cmp++;
        assert (seg === e_seg) else begin
            n_fail++;
            $error("FAIL seg: observed %h expected %h at %0t", seg, e_seg, $time);
        end
        n_cmp++;
        assert (dp === e_dp) else begin
            n_fail++;
            $error("FAIL dp: observed %b expected %b at %0t", dp, e_dp, $time);
        end
        n_cmp++;
        assert (frame_done === e_fd) else begin
            n_fail++;
            $error("FAIL frame_done: observed %b expected %b at %0t", frame_done, e_fd, $time);
        end
        if (frame_done === 1'b1) fd_count++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        fd_count = 0;
        m_cnt    = 0;
        m_idx    = 0;
        m_snap   = 16'h0000;
        m_sdp    = 4'h0;

        // Reset held with enable high and live data.
        reset   = 1'b1;
        en      = 1'b1;
        digits  = 16'h1234;
        dp_mask = 4'b0010;
        run(3);

        // Scan order, blanking and frame pulse over two frames.
        reset    = 1'b0;
        fd_count = 0;
        run(64);
        n_cmp++;
        assert (fd_count == 2) else begin
            n_fail++;
            $error("FAIL frame_count: observed %0d expected %0d", fd_count, 2);
        end

        // Snapshot: data changed in slot 2 stays hidden until the next frame.
        for (int k = 0; k < 64 && !(m_idx == 2 && m_cnt == 3); k++) tick();
        digits = 16'hABCD;
        run(48);

        // Enable drop mid-slot 3 with changing data, then resume.
        for (int k = 0; k < 64 && !(m_idx == 3 && m_cnt == 4); k++) tick();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            digits  = 16'($urandom);
            dp_mask = 4'($urandom);
            tick();
        end
        en = 1'b1;
        run(40);

        // Decode sweep on digit 0, one value per two frames.
        for (int v = 0; v < 16; v++) begin
            digits  = {4'($urandom), 4'($urandom), 4'($urandom), 4'(v)};
            dp_mask = 4'($urandom);
            run(64);
        end

        // Leading-zero patterns (plain decode when the option is off).
        digits  = 16'h0050;
        dp_mask = 4'b1000;
        run(64);
        digits  = 16'h0000;
        dp_mask = 4'b0000;
        run(64);

        // Reset pulse mid-slot.
        for (int k = 0; k < 64 && !(m_idx == 1 && m_cnt == 5); k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(40);

        // Randomised traffic: data churn, enable drops, occasional reset.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                digits = 16'($urandom) & {{4{1'($urandom)}}, {4{1'($urandom)}},
                                          {4{1'($urandom)}}, {4{1'($urandom)}}};
            end
            if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom);
            en    = ($urandom_range(0, 19) != 0);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        en    = 1'b1;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
